// File: rtl/fibonacci_engine.sv
// fibonacci_engine: Fibonacci term generator with loadable seeds, term count,
// optional pacing and a valid/ready output stream. Flags wrap-around of the
// running sum and toggles a status LED on every accepted term.
//
// Stream handshake: term_valid_out is high only in EMIT and does not depend
// on term_ready_in. A term is transferred on a rising clock edge where
// term_valid_out and term_ready_in are both high. While valid is high and
// ready is low, term_out and term_index_out hold steady.
module fibonacci_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int COUNT_WIDTH  = 8,
  parameter int PERIOD       = 1600,
  parameter int PERIOD_WIDTH = 11
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   start_in,
  input  logic [DATA_WIDTH-1:0]  seed_a_in,
  input  logic [DATA_WIDTH-1:0]  seed_b_in,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   paced_in,
  input  logic                   term_ready_in,
  output logic                   term_valid_out,
  output logic [DATA_WIDTH-1:0]  term_out,
  output logic [COUNT_WIDTH-1:0] term_index_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   overflow_out,
  output logic                   led_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // WAIT lasts PERIOD-1 cycles, so handshakes are exactly PERIOD cycles apart.
  localparam logic [PERIOD_WIDTH-1:0] TMR_LOAD = PERIOD_WIDTH'(PERIOD - 2);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [COUNT_WIDTH-1:0]  rem_q;
  logic [COUNT_WIDTH-1:0]  idx_q;
  logic [PERIOD_WIDTH-1:0] tmr_q;
  logic                    mode_q;
  logic                    ovf_q;
  logic                    led_q;

  // Full-width sum keeps the carry-out for the wrap flag.
  logic [DATA_WIDTH:0] sum_d;
  logic                final_d;

  assign sum_d   = {1'b0, a_q} + {1'b0, b_q};
  assign final_d = (rem_q == COUNT_WIDTH'(1));

  // Single FSM: run control, datapath registers, wrap flag and LED.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            a_q     <= seed_a_in;
            b_q     <= seed_b_in;
            rem_q   <= count_in;
            idx_q   <= '0;
            mode_q  <= paced_in;
            ovf_q   <= 1'b0;
            state_q <= (count_in == '0) ? S_DONE : S_EMIT;
          end
        end
        S_EMIT: begin
          if (term_ready_in) begin
            a_q   <= b_q;
            b_q   <= sum_d[DATA_WIDTH-1:0];
            idx_q <= idx_q + COUNT_WIDTH'(1);
            rem_q <= rem_q - COUNT_WIDTH'(1);
            led_q <= ~led_q;
            if (final_d) begin
              // The sum after the last term is never emitted, so its carry is ignored.
              state_q <= S_DONE;
            end else begin
              ovf_q <= ovf_q | sum_d[DATA_WIDTH];
              if (mode_q) begin
                tmr_q   <= TMR_LOAD;
                state_q <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (tmr_q == '0) begin
            state_q <= S_EMIT;
          end else begin
            tmr_q <= tmr_q - PERIOD_WIDTH'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from state and registers only.
  assign term_valid_out = (state_q == S_EMIT);
  assign term_out       = a_q;
  assign term_index_out = idx_q;
  assign busy_out       = (state_q != S_IDLE);
  assign done_out       = (state_q == S_DONE);
  assign overflow_out   = ovf_q;
  assign led_out        = led_q;

endmodule

// File: tb/tb_fibonacci_engine.sv
// Bench for fibonacci_engine: directed runs plus a sequence-level model
// (expected term queue built from seeds and count) checked every cycle.
module tb_fibonacci_engine;

  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int PER = 4;
  localparam int PW  = 3;

  // clock / reset block
  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] seed_a;
  logic [DW-1:0] seed_b;
  logic [CW-1:0] count;
  logic          paced;
  logic          ready;

  logic          term_valid_out;
  logic [DW-1:0] term_out;
  logic [CW-1:0] term_index_out;
  logic          busy_out;
  logic          done_out;
  logic          overflow_out;
  logic          led_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  fibonacci_engine #(
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW),
    .PERIOD      (PER),
    .PERIOD_WIDTH(PW)
  ) dut (
    .clock_in      (clk),
    .reset_in      (rst),
    .start_in      (start),
    .seed_a_in     (seed_a),
    .seed_b_in     (seed_b),
    .count_in      (count),
    .paced_in      (paced),
    .term_ready_in (ready),
    .term_valid_out(term_valid_out),
    .term_out      (term_out),
    .term_index_out(term_index_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .overflow_out  (overflow_out),
    .led_out       (led_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard / model state
  logic [DW-1:0] exp_q[$];
  int            m_idx   = 0;
  bit            m_ovf   = 0;
  bit            m_led   = 0;
  bit            m_done  = 0;
  bit            m_paced = 0;

  // run logs used by the directed checks
  logic [DW-1:0] got_q[$];
  int            hs_cyc[$];
  int            valid_cyc[$];
  int            s_cyc     = -1;
  int            done_cyc  = -1;
  int            ovf_rise  = -1;
  int            busy_cnt  = 0;
  int            done_cnt  = 0;
  bit            prev_ovf  = 0;

  // compare process: checks outputs each cycle, then advances the model
  initial begin
    bit            nd;
    logic [DW-1:0] x, y, z;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("done", done_out, m_done);
      chk("busy", busy_out, (exp_q.size() > 0) || m_done);
      chk("overflow", overflow_out, m_ovf);
      chk("led", led_out, m_led);
      if (term_valid_out) begin
        if (exp_q.size() == 0) chk("valid_extra", 1, 0);
        else begin
          chk("term", term_out, exp_q[0]);
          chk("index", term_index_out, m_idx);
        end
      end else if (!m_paced && exp_q.size() > 0) begin
        chk("valid_unpaced", 0, 1);
      end

      if (term_valid_out) valid_cyc.push_back(cyc);
      if (done_out) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (busy_out) busy_cnt++;
      if (overflow_out && !prev_ovf) ovf_rise = cyc;
      prev_ovf = overflow_out;

      nd = 0;
      if (rst) begin
        exp_q.delete();
        m_ovf = 0;
        m_led = 0;
        m_idx = 0;
      end else if (exp_q.size() == 0 && !m_done) begin
        if (start) begin
          m_ovf   = 0;
          m_idx   = 0;
          m_paced = paced;
          s_cyc   = cyc;
          got_q.delete();
          hs_cyc.delete();
          valid_cyc.delete();
          busy_cnt = 0;
          done_cyc = -1;
          ovf_rise = -1;
          x = seed_a;
          y = seed_b;
          for (int i = 0; i < int'(count); i++) begin
            exp_q.push_back(x);
            z = x + y;
            x = y;
            y = z;
          end
          if (count == 0) nd = 1;
        end
      end else if (term_valid_out && ready && exp_q.size() > 0) begin
        got_q.push_back(term_out);
        hs_cyc.push_back(cyc);
        m_led = !m_led;
        m_idx++;
        if (exp_q.size() == 1) nd = 1;
        else if (int'(exp_q[0]) + int'(exp_q[1]) > (1 << DW) - 1) m_ovf = 1;
        void'(exp_q.pop_front());
      end
      m_done = nd;
    end
  end

  // driver tasks (called positioned just after a rising edge)
  task automatic start_run(input int a, input int b, input int n, input bit p);
    seed_a = DW'(a);
    seed_b = DW'(b);
    count  = CW'(n);
    paced  = p;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (done_cnt != d0) ok = 1;
    end
    #1;
    chk("run_finished", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit10[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    int lit5[5]   = '{2, 3, 5, 8, 13};
    int d_prev;
    int d0;
    rst = 1; start = 0; paced = 0; ready = 1;
    seed_a = '0; seed_b = '0; count = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // reset values
    chk("rst_valid", term_valid_out, 0);
    chk("rst_term", term_out, 0);
    chk("rst_index", term_index_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_ovf", overflow_out, 0);
    chk("rst_led", led_out, 0);
    @(posedge clk); #1;

    // basic unpaced run, seeds 0/1, 10 terms
    start_run(0, 1, 10, 0);
    wait_done(40);
    chk("t1_len", got_q.size(), 10);
    if (got_q.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("t1_term", got_q[i], lit10[i]);
        chk("t1_cycle", hs_cyc[i], s_cyc + 1 + i);
      end
    end
    chk("t1_done_cycle", done_cyc, s_cyc + 11);
    chk("t1_led", led_out, 0);
    chk("t1_ovf", overflow_out, 0);
    d_prev = done_cyc;

    // earliest restart, 15 terms wrapping at idx14
    start_run(0, 1, 15, 0);
    chk("t2_restart_cycle", s_cyc, d_prev + 1);
    wait_done(50);
    chk("t2_len", got_q.size(), 15);
    if (got_q.size() == 15) begin
      chk("t2_idx13", got_q[13], 233);
      chk("t2_idx14", got_q[14], 121);
      chk("t2_ovf_rise", ovf_rise, hs_cyc[12] + 1);
    end
    chk("t2_ovf_sticky", overflow_out, 1);

    // backpressure on idx1; start clears overflow
    start_run(0, 1, 3, 0);
    chk("t3_ovf_clear", overflow_out, 0);
    @(posedge clk); #1;
    ready = 0;
    repeat (4) begin
      @(negedge clk);
      chk("t3_hold_valid", term_valid_out, 1);
      chk("t3_hold_term", term_out, 1);
      chk("t3_hold_index", term_index_out, 1);
      @(posedge clk); #1;
    end
    ready = 1;
    wait_done(30);
    chk("t3_len", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("t3_term2", got_q[2], 1);
      chk("t3_resume_cycle", hs_cyc[1], s_cyc + 6);
    end

    // paced mode, PERIOD=4
    start_run(0, 1, 3, 1);
    wait_done(60);
    chk("t4_valid_count", valid_cyc.size(), 3);
    if (valid_cyc.size() == 3) begin
      chk("t4_valid0", valid_cyc[0], s_cyc + 1);
      chk("t4_valid1", valid_cyc[1], s_cyc + 5);
      chk("t4_valid2", valid_cyc[2], s_cyc + 9);
    end
    chk("t4_done_cycle", done_cyc, s_cyc + 10);

    // zero-length run
    start_run(7, 7, 0, 0);
    wait_done(10);
    chk("t5_done_cycle", done_cyc, s_cyc + 1);
    chk("t5_busy_cycles", busy_cnt, 1);
    chk("t5_no_valid", valid_cyc.size(), 0);

    // mid-run start (ignored) and reset (abandons run)
    d0 = done_cnt;
    start_run(0, 1, 20, 0);
    repeat (5) begin @(posedge clk); #1; end
    seed_a = 9; seed_b = 9; count = 2; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("t6_ignore_start_idx", term_index_out, 6);
    chk("t6_ignore_start_term", term_out, 8);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1; start = 1; seed_a = 2; seed_b = 3; count = 4;
    @(posedge clk); #1;
    rst = 0; start = 0;
    chk("t6_rst_valid", term_valid_out, 0);
    chk("t6_rst_term", term_out, 0);
    chk("t6_rst_index", term_index_out, 0);
    chk("t6_rst_busy", busy_out, 0);
    chk("t6_rst_ovf", overflow_out, 0);
    chk("t6_rst_led", led_out, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_no_done", done_cnt, d0);
    chk("t6_len", got_q.size(), 8);
    if (got_q.size() == 8) chk("t6_idx7", got_q[7], 13);

    start_run(2, 3, 5, 0);
    wait_done(30);
    chk("t6b_len", got_q.size(), 5);
    if (got_q.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("t6b_term", got_q[i], lit5[i]);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fibonacci_engine.md
# fibonacci_engine

Parametrised Fibonacci sequence generator that replaces the fixed 4-bit, register-chain Fibonacci datapath with a single FSM-driven engine. It accepts loadable seeds, a term count and a pacing mode, and emits terms over a valid/ready stream. It flags arithmetic wrap-around and drives a status LED. It sits between the board-level top and any consumer (display driver, UART framer, or the LED alone).

## Interface
Parameters:
- DATA_WIDTH, 8, width of seeds and terms
- COUNT_WIDTH, 8, width of term count and term index
- PERIOD, 1600, minimum clock cycles between successive handshakes in paced mode; legal range is ≥2
- PERIOD_WIDTH, 11, timer width; must satisfy 2^PERIOD_WIDTH > PERIOD

Ports:
- clock_in  in  1  sole clock
- reset_in  in  1  synchronous, active-high reset
- start_in  in  1  start request; sampled only in IDLE
- seed_a_in  in  DATA_WIDTH  F0, captured on start
- seed_b_in  in  DATA_WIDTH  F1, captured on start
- count_in  in  COUNT_WIDTH  number of terms to emit, captured on start; 0 is legal
- paced_in  in  1  1 = paced by PERIOD, 0 = full rate; captured on start
- term_ready_in  in  1  downstream ready
- term_valid_out  out  1  term_out is valid
- term_out  out  DATA_WIDTH  current term
- term_index_out  out  COUNT_WIDTH  index of current term, starting at 0
- busy_out  out  1  engine not in IDLE
- done_out  out  1  one-cycle pulse at end of run
- overflow_out  out  1  sticky wrap flag; cleared only by start or reset
- led_out  out  1  toggles on every handshake

## Operation
- Registers:
  - a: current term
  - b: next term
  - rem: terms remaining
  - idx: current index
  - tmr: pacing timer
  - mode: latched paced_in
- FSM states: IDLE, EMIT, WAIT, DONE.
- IDLE, start_in=1:
  - a←seed_a_in, b←seed_b_in, rem←count_in, idx←0, mode←paced_in, overflow←0.
  - If count_in=0, go to DONE; otherwise go to EMIT.
- EMIT:
  - term_valid_out=1, term_out=a, term_index_out=idx.
  - Handshake occurs when term_valid_out & term_ready_in.
  - Without a handshake, hold all registers and outputs.
- On handshake:
  - a←b, b←(a+b) truncated to DATA_WIDTH, idx←idx+1, rem←rem−1, led toggles.
  - If rem=1, this was the final term: go to DONE; the sum and its carry are discarded and do not affect overflow.
  - Otherwise, overflow←overflow | carry-out of a+b.
  - Next state, not final, mode=0: stay in EMIT.
  - Next state, not final, mode=1: go to WAIT with tmr←PERIOD−2.
- WAIT: term_valid_out=0. If tmr=0, go to EMIT; otherwise tmr←tmr−1.
- DONE: done_out=1 for exactly one cycle, then go to IDLE.
- busy_out = (state≠IDLE), which includes DONE.
- start_in outside IDLE is ignored; it is not queued.
- term_ready_in is ignored outside EMIT.
- Wrapped terms continue to be emitted modulo 2^DATA_WIDTH; the engine does not halt on overflow.

## Timing
- Reset values: state=IDLE, all outputs 0 (term_out=0, term_index_out=0, led_out=0, overflow_out=0).
- Reset has priority over every other event, including reset mid-run. The run is abandoned, no done_out pulse is produced, and start_in is ignored in the reset cycle.
- All outputs are registered or decoded from state/registers only; there is no combinational path from any input to any output.
- Start accepted in cycle s:
  - count≠0: term_valid_out=1 with term 0 in cycle s+1, in both modes.
  - count=0: done_out=1 in cycle s+1, and term_valid_out is never asserted.
- Unpaced mode with ready held high: one term per cycle; N terms occupy cycles s+1..s+N, done_out in s+N+1.
- Paced mode, handshake in cycle c: valid low in c+1..c+PERIOD−1, valid high in c+PERIOD.
- Final handshake in cycle c: done_out in c+1, IDLE in c+2. The earliest next start is accepted in c+2.
- overflow_out rises in the cycle after the handshake that produced the wrap.

## Test plan
- DATA_WIDTH=8, seeds 0/1, count 10, unpaced, ready=1:
  - terms 0,1,1,2,3,5,8,13,21,34 on 10 consecutive cycles, idx 0..9;
  - done_out one cycle later; overflow_out=0; led_out toggled 10 times (ends at 0).
- DATA_WIDTH=8, seeds 0/1, count 15:
  - idx13=233, idx14=121 (377 mod 256);
  - overflow_out rises the cycle after the idx12 handshake and stays 1 after done;
  - next start clears it.
- Backpressure: run 3 terms, ready low for 4 cycles while idx1 is valid:
  - term_out=1, idx=1, valid=1 held stable throughout;
  - sequence resumes correctly when ready returns high.
- Paced, PERIOD=4, count 3, ready=1:
  - valid high in cycles s+1, s+5, s+9 only;
  - done_out in s+10.
- count=0: done_out in s+1, busy_out high only in s+1, term_valid_out never asserted.
- Mid-run events during a count-20 run:
  - start_in pulsed at idx5: no effect on the run;
  - reset_in at idx8: all outputs 0 the next cycle, no done_out;
  - fresh start with seeds 2/3 then yields 2,3,5,….
